// File: rtl/sstv_pkg.sv
// sstv_pkg: shared constants, enums and helpers for the SSTV receive sequencer.
//   - Tone frequencies (Hz) for header/VIS classification and the luminance range.
//   - Frame geometry (160 x 120, row-major).
//   - state_t / tone_t enums, saturating 16-bit increment, pixel quantizer.
package sstv_pkg;

  localparam logic [11:0] FREQ_1100  = 12'd1100;
  localparam logic [11:0] FREQ_1200  = 12'd1200;
  localparam logic [11:0] FREQ_1300  = 12'd1300;
  localparam logic [11:0] FREQ_1900  = 12'd1900;
  localparam logic [11:0] FREQ_BLACK = 12'd1500;
  localparam logic [11:0] FREQ_WHITE = 12'd2300;

  localparam int IMG_W     = 160;
  localparam int IMG_H     = 120;
  localparam int PIX_TOTAL = IMG_W * IMG_H;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEADER1, ST_BREAK, ST_LEADER2,
    ST_START, ST_VIS, ST_STOP, ST_PIXELS
  } state_t;

  typedef enum logic [2:0] {
    TONE_OTHER, TONE_1900, TONE_1200, TONE_1100, TONE_1300
  } tone_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Clamp to [BLACK, WHITE], then bucket into 200 Hz steps by threshold
  // compare; 2100..2300 all land in the top bucket.
  function automatic logic [1:0] quant_pix(input logic [11:0] f);
    logic [11:0] d;
    if (f <= FREQ_BLACK)      d = 12'd0;
    else if (f >= FREQ_WHITE) d = FREQ_WHITE - FREQ_BLACK;
    else                      d = f - FREQ_BLACK;
    if (d >= 12'd600)      return 2'd3;
    else if (d >= 12'd400) return 2'd2;
    else if (d >= 12'd200) return 2'd1;
    else                   return 2'd0;
  endfunction

endpackage

// File: rtl/sstv_tone_class.sv
// sstv_tone_class: registered tone classifier (1-cycle latency).
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset
//   freq_i  - instantaneous frequency estimate, Hz
//   tone_o  - registered tone class
//   freq_o  - freq_i delayed by the same cycle, so pixel sampling stays
//             aligned with the classified stream
module sstv_tone_class
  import sstv_pkg::*;
#(
  parameter int FREQ_TOL = 50
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [11:0] freq_i,
  output tone_t       tone_o,
  output logic [11:0] freq_o
);

  tone_t       tone_d, tone_q;
  logic [11:0] freq_q;

  function automatic logic in_win(input logic [11:0] f, input logic [11:0] c);
    logic [12:0] lo, hi;
    lo = {1'b0, c} - 13'(FREQ_TOL);
    hi = {1'b0, c} + 13'(FREQ_TOL);
    return ({1'b0, f} >= lo) && ({1'b0, f} <= hi);
  endfunction

  // Windows of adjacent tones touch at the edges; earlier entries win.
  always_comb begin
    tone_d = TONE_OTHER;
    if (in_win(freq_i, FREQ_1900))      tone_d = TONE_1900;
    else if (in_win(freq_i, FREQ_1200)) tone_d = TONE_1200;
    else if (in_win(freq_i, FREQ_1100)) tone_d = TONE_1100;
    else if (in_win(freq_i, FREQ_1300)) tone_d = TONE_1300;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tone_q <= TONE_OTHER;
      freq_q <= 12'd0;
    end else begin
      tone_q <= tone_d;
      freq_q <= freq_i;
    end
  end

  assign tone_o = tone_q;
  assign freq_o = freq_q;

endmodule

// File: rtl/sstv_rx_ctrl.sv
// sstv_rx_ctrl: SSTV receive sequencer. Walks the calibration header and VIS
// word on the classified tone stream, then writes one quantized pixel per
// pixel period for a full 160x120 frame.
//   clk       - system clock (one tick)
//   reset     - asynchronous active-high reset
//   freq      - instantaneous frequency, Hz
//   vis_code  - last parity-checked VIS mode
//   vis_valid - vis_code is valid for the current reception
//   vis_err   - one-cycle pulse on header/VIS abort
//   vid_addr  - frame-buffer address of the current write
//   vid_pixel - 2-bit luminance of the current write
//   vid_we    - one-cycle write strobe
//   busy      - high in every state but IDLE
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a 1900 Hz tone
// LEADER1  | counting first 1900 Hz leader run
// BREAK    | counting 1200 Hz break run
// LEADER2  | counting second 1900 Hz leader run
// START    | checking start bit at mid-bit
// VIS      | sampling 8 VIS bits (LSB first) at mid-bit
// STOP     | checking stop bit and parity, then waiting for pixel start
// PIXELS   | one write strobe per pixel period until the frame completes
module sstv_rx_ctrl
  import sstv_pkg::*;
#(
  parameter int TICKS_LEADER_MIN = 24000,
  parameter int TICKS_BREAK_MIN  = 500,
  parameter int TICKS_BREAK_MAX  = 1500,
  parameter int TICKS_BIT        = 3000,
  parameter int TICKS_PIXEL      = 36,
  parameter int FREQ_TOL         = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] freq,
  output logic [6:0]  vis_code,
  output logic        vis_valid,
  output logic        vis_err,
  output logic [14:0] vid_addr,
  output logic [1:0]  vid_pixel,
  output logic        vid_we,
  output logic        busy
);

  localparam logic [15:0] L_MIN     = 16'(TICKS_LEADER_MIN);
  localparam logic [15:0] B_MIN     = 16'(TICKS_BREAK_MIN);
  localparam logic [15:0] B_MAX     = 16'(TICKS_BREAK_MAX);
  localparam logic [15:0] BIT_T     = 16'(TICKS_BIT);
  localparam logic [15:0] BIT_HALF  = 16'(TICKS_BIT / 2);
  localparam logic [15:0] STOP_LAST = 16'(10 * TICKS_BIT - 1);
  localparam logic [15:0] PIX_HALF  = 16'(TICKS_PIXEL / 2);
  localparam logic [15:0] PIX_LAST  = 16'(TICKS_PIXEL - 1);
  localparam logic [14:0] ADDR_LAST = 15'(PIX_TOTAL - 1);

  tone_t       tone_q;
  logic [11:0] freq_q;

  state_t      state_d, state_q;
  logic [15:0] run_d, run_q;
  logic [15:0] tmr_d, tmr_q;
  logic [15:0] nxt_d, nxt_q;     // bit-timer value of the next mid-bit sample
  logic [2:0]  bit_d, bit_q;
  logic [7:0]  sh_d, sh_q;
  logic [15:0] ptmr_d, ptmr_q;
  logic [14:0] pcnt_d, pcnt_q;   // address of the next pixel to write
  logic [6:0]  code_d, code_q;
  logic        valid_d, valid_q;
  logic        err_d, err_q;
  logic [14:0] addr_d, addr_q;
  logic [1:0]  pix_d, pix_q;
  logic        we_d, we_q;

  sstv_tone_class #(.FREQ_TOL(FREQ_TOL)) u_class (
    .clk_i  (clk),
    .rst_i  (reset),
    .freq_i (freq),
    .tone_o (tone_q),
    .freq_o (freq_q)
  );

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    tmr_d   = sat_inc16(tmr_q);
    nxt_d   = nxt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    ptmr_d  = ptmr_q;
    pcnt_d  = pcnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    pix_d   = pix_q;
    we_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        run_d   = 16'd0;
        valid_d = 1'b0;
        if (tone_q == TONE_1900) begin
          state_d = ST_LEADER1;
          run_d   = 16'd1;
        end
      end

      // A short first leader is just noise: drop back silently.
      ST_LEADER1: begin
        if (tone_q == TONE_1900) begin
          run_d = sat_inc16(run_q);
        end else if (tone_q == TONE_1200 && run_q >= L_MIN) begin
          state_d = ST_BREAK;
          run_d   = 16'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_BREAK: begin
        if (tone_q == TONE_1200) begin
          if (run_q >= B_MAX) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else begin
            run_d = sat_inc16(run_q);
          end
        end else if (tone_q == TONE_1900 && run_q >= B_MIN) begin
          state_d = ST_LEADER2;
          run_d   = 16'd1;
        end else begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end

      ST_LEADER2: begin
        if (tone_q == TONE_1900) begin
          run_d = sat_inc16(run_q);
        end else if (tone_q == TONE_1200 && run_q >= L_MIN) begin
          state_d = ST_START;
          tmr_d   = 16'd0;
          nxt_d   = BIT_HALF;
        end else begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end

      ST_START: begin
        if (tmr_q == nxt_q) begin
          if (tone_q == TONE_1200) begin
            state_d = ST_VIS;
            bit_d   = 3'd0;
            nxt_d   = nxt_q + BIT_T;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end

      ST_VIS: begin
        if (tmr_q == nxt_q) begin
          if (tone_q == TONE_1100 || tone_q == TONE_1300) begin
            sh_d  = {tone_q == TONE_1100, sh_q[7:1]};
            nxt_d = nxt_q + BIT_T;
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = ST_STOP;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end

      // After a good stop sample the state just waits out the stop bit.
      ST_STOP: begin
        if (tmr_q == nxt_q) begin
          if (tone_q == TONE_1200 && (^sh_q) == 1'b0) begin
            code_d  = sh_q[6:0];
            valid_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else if (tmr_q == STOP_LAST) begin
          state_d = ST_PIXELS;
          ptmr_d  = 16'd0;
          pcnt_d  = 15'd0;
        end
      end

      ST_PIXELS: begin
        ptmr_d = (ptmr_q == PIX_LAST) ? 16'd0 : ptmr_q + 16'd1;
        if (ptmr_q == PIX_HALF) begin
          we_d   = 1'b1;
          pix_d  = quant_pix(freq_q);
          addr_d = pcnt_q;
          if (pcnt_q == ADDR_LAST) state_d = ST_IDLE;
          else                     pcnt_d  = pcnt_q + 15'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      run_q   <= 16'd0;
      tmr_q   <= 16'd0;
      nxt_q   <= 16'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      ptmr_q  <= 16'd0;
      pcnt_q  <= 15'd0;
      code_q  <= 7'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 15'd0;
      pix_q   <= 2'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tmr_q   <= tmr_d;
      nxt_q   <= nxt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      ptmr_q  <= ptmr_d;
      pcnt_q  <= pcnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      we_q    <= we_d;
    end
  end

  assign vis_code  = code_q;
  assign vis_valid = valid_q;
  assign vis_err   = err_q;
  assign vid_addr  = addr_q;
  assign vid_pixel = pix_q;
  assign vid_we    = we_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sstv_rx_ctrl.sv
// Directed testbench for sstv_rx_ctrl with shortened header/bit/pixel timing.
module tb_sstv_rx_ctrl;

  localparam int LMIN = 40;
  localparam int BMIN = 10;
  localparam int BMAX = 30;
  localparam int BIT  = 20;
  localparam int PIX  = 2;
  localparam int NPIX = 19200;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] freq;
  logic [6:0]  vis_code;
  logic        vis_valid;
  logic        vis_err;
  logic [14:0] vid_addr;
  logic [1:0]  vid_pixel;
  logic        vid_we;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  // monitor state
  int cyc = 0, last_we = 0, exp_addr = 0;
  int we_cnt = 0, err_cnt = 0, seq_err = 0, sp_err = 0;

  logic [11:0] qf[6]   = '{12'd1400, 12'd1699, 12'd1700, 12'd2099, 12'd2100, 12'd4095};
  int          qexp[6] = '{0, 0, 1, 2, 3, 3};

  sstv_rx_ctrl #(
    .TICKS_LEADER_MIN (LMIN),
    .TICKS_BREAK_MIN  (BMIN),
    .TICKS_BREAK_MAX  (BMAX),
    .TICKS_BIT        (BIT),
    .TICKS_PIXEL      (PIX),
    .FREQ_TOL         (50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .freq      (freq),
    .vis_code  (vis_code),
    .vis_valid (vis_valid),
    .vis_err   (vis_err),
    .vid_addr  (vid_addr),
    .vid_pixel (vid_pixel),
    .vid_we    (vid_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (vis_err) err_cnt = err_cnt + 1;
    if (vid_we) begin
      we_cnt = we_cnt + 1;
      if (32'(vid_addr) != exp_addr) seq_err = seq_err + 1;
      if (exp_addr != 0 && (cyc - last_we) != PIX) sp_err = sp_err + 1;
      last_we  = cyc;
      exp_addr = exp_addr + 1;
    end else if (!busy) begin
      exp_addr = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] f, input int n);
    freq = f;
    repeat (n) @(negedge clk);
  endtask

  // Leader, break, leader, start bit, 8 VIS bits; leaves the stop tone on.
  task automatic send_header(input logic [7:0] vis, input int bad_bit,
                             input int lead_len, input int brk_len);
    drive(12'd1900, lead_len);
    drive(12'd1200, brk_len);
    drive(12'd1900, lead_len);
    drive(12'd1200, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == bad_bit)  drive(12'd1700, BIT);
      else if (vis[i])   drive(12'd1100, BIT);
      else               drive(12'd1300, BIT);
    end
    freq = 12'd1200;
  endtask

  task automatic wait_valid(output int ok);
    ok = 0;
    for (int i = 0; i < 2 * BIT; i++) begin
      @(negedge clk);
      if (vis_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int ok, we0, er0;

    reset = 1'b1;
    freq  = 12'd0;
    repeat (3) @(negedge clk);
    check("rst_vis_code",  32'(vis_code),  0);
    check("rst_vis_valid", 32'(vis_valid), 0);
    check("rst_vis_err",   32'(vis_err),   0);
    check("rst_vid_addr",  32'(vid_addr),  0);
    check("rst_vid_pixel", 32'(vid_pixel), 0);
    check("rst_vid_we",    32'(vid_we),    0);
    check("rst_busy",      32'(busy),      0);
    reset = 1'b0;
    @(negedge clk);

    // nominal frame with quantization on the first six pixels
    we0 = we_cnt;
    er0 = err_cnt;
    send_header(8'h88, -1, 50, 20);
    wait_valid(ok);
    check("nom_vis_valid", ok, 1);
    check("nom_vis_code", 32'(vis_code), 8);
    check("nom_no_we_before_valid", we_cnt - we0, 0);
    freq = qf[0];
    for (int k = 0; k < 6; k++) begin
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (vid_we) begin
          ok = 1;
          break;
        end
      end
      check("quant_strobe", ok, 1);
      check("quant_pixel", 32'(vid_pixel), qexp[k]);
      check("quant_addr", 32'(vid_addr), k);
      freq = (k < 5) ? qf[k + 1] : 12'd2100;
    end
    ok = 0;
    for (int i = 0; i < NPIX * PIX + 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    freq = 12'd0;
    check("nom_frame_end", ok, 1);
    repeat (3) @(negedge clk);
    check("nom_strobe_count", we_cnt - we0, NPIX);
    check("nom_addr_sequence", seq_err, 0);
    check("nom_strobe_spacing", sp_err, 0);
    check("nom_last_addr", 32'(vid_addr), NPIX - 1);
    check("nom_busy_after", 32'(busy), 0);
    check("nom_valid_idle", 32'(vis_valid), 0);
    check("nom_code_held", 32'(vis_code), 8);
    check("nom_no_err", err_cnt - er0, 0);

    // parity error
    we0 = we_cnt;
    er0 = err_cnt;
    send_header(8'h08, -1, 50, 20);
    drive(12'd1200, BIT);
    drive(12'd0, 5);
    check("par_err_pulse", err_cnt - er0, 1);
    check("par_valid", 32'(vis_valid), 0);
    check("par_busy", 32'(busy), 0);
    check("par_no_we", we_cnt - we0, 0);

    // bad tone during VIS bit 3
    we0 = we_cnt;
    er0 = err_cnt;
    send_header(8'h88, 3, 50, 20);
    drive(12'd1200, BIT);
    drive(12'd0, 5);
    check("bad_err_pulse", err_cnt - er0, 1);
    check("bad_valid", 32'(vis_valid), 0);
    check("bad_busy", 32'(busy), 0);
    check("bad_no_we", we_cnt - we0, 0);

    // short leader, silent return
    er0 = err_cnt;
    drive(12'd1900, 10);
    check("short_busy_in_leader", 32'(busy), 1);
    drive(12'd1900, 5);
    drive(12'd1200, 5);
    check("short_busy_dropped", 32'(busy), 0);
    drive(12'd0, 5);
    check("short_no_err", err_cnt - er0, 0);

    // full header at the exact minimum leader/break lengths, then reset mid-frame
    send_header(8'h88, -1, LMIN, BMIN);
    wait_valid(ok);
    check("min_hdr_valid", ok, 1);
    check("min_hdr_code", 32'(vis_code), 8);
    freq = 12'd2100;
    ok = 0;
    for (int i = 0; i < 5001 * PIX + 200; i++) begin
      @(negedge clk);
      if (vid_we && vid_addr == 15'd5000) begin
        ok = 1;
        break;
      end
    end
    check("reach_pixel_5000", ok, 1);
    check("pixel_5000_value", 32'(vid_pixel), 3);
    reset = 1'b1;
    #1;
    check("mid_rst_vid_we",    32'(vid_we),    0);
    check("mid_rst_vid_addr",  32'(vid_addr),  0);
    check("mid_rst_vid_pixel", 32'(vid_pixel), 0);
    check("mid_rst_busy",      32'(busy),      0);
    check("mid_rst_vis_valid", 32'(vis_valid), 0);
    check("mid_rst_vis_code",  32'(vis_code),  0);
    check("mid_rst_vis_err",   32'(vis_err),   0);
    @(negedge clk);
    we0 = we_cnt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(12'd0, 100);
    check("no_we_after_reset", we_cnt - we0, 0);
    check("idle_after_reset", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sstv_rx_ctrl.md
# sstv_rx_ctrl

Receive-side sequencer for the SSTV decoder. It consumes the per-clock frequency estimate and walks the calibration header: leader, break, leader, then the start bit. It then samples the 8-bit VIS word and checks parity. On a valid header it schedules one 2-bit pixel sample per pixel period and issues a write strobe plus frame-buffer address for the whole 160×120 frame, then returns to idle. It sits between the frequency estimator and the video RAM, and is the single owner of `vis_code`/`vis_valid` and the `vid_*` write port.

## Interface
- `TICKS_LEADER_MIN`, 24000 — consecutive 1900 Hz ticks that qualify a leader (80% of 300 ms at 10 µs/tick).
- `TICKS_BREAK_MIN`, 500 — minimum 1200 Hz break length.
- `TICKS_BREAK_MAX`, 1500 — maximum 1200 Hz break length.
- `TICKS_BIT`, 3000 — VIS bit period (30 ms).
- `TICKS_PIXEL`, 36 — pixel period.
- `FREQ_TOL`, 50 — ± Hz window for tone classification.
- `clk` in 1 — system clock; one clock equals one tick.
- `reset` in 1 — asynchronous, active-high; returns all state to IDLE.
- `freq` in 12 — instantaneous frequency, Hz, unsigned.
- `vis_code` out 7 — decoded VIS mode, LSB received first.
- `vis_valid` out 1 — level; `vis_code` holds a parity-checked value.
- `vis_err` out 1 — one-cycle pulse on any header or VIS abort.
- `vid_addr` out 15 — pixel index 0..19199, row-major, 160 per row.
- `vid_pixel` out 2 — quantized luminance.
- `vid_we` out 1 — one-cycle write strobe.
- `busy` out 1 — high in every state except IDLE.

## Operation
- **Classifier:** registered, 1-cycle latency. Output class is one of:
  - T1900 (|freq−1900| ≤ TOL)
  - T1200
  - T1100 (mark, bit value 1)
  - T1300 (space, bit value 0)
  - OTHER
- **States:** IDLE, LEADER1, BREAK, LEADER2, START, VIS, STOP, PIXELS.
- **IDLE:** a T1900 class goes to LEADER1. The run counter is cleared, `vis_valid` is cleared, and `vis_code` is held.
- **LEADER1:** counts the consecutive T1900 run.
  - T1200 with run ≥ LEADER_MIN → BREAK.
  - Any other class change → IDLE, with no `vis_err` pulse.
- **BREAK:** counts the T1200 run.
  - T1900 with run in [BREAK_MIN, BREAK_MAX] → LEADER2.
  - Run > BREAK_MAX, or any other class → IDLE plus `vis_err`.
- **LEADER2:** same qualification as LEADER1.
  - T1200 after a qualified run → START. The bit timer is zeroed on this edge.
  - T1200 before the run qualifies, or any non-T1900/T1200 class → IDLE plus `vis_err`.
- **START:** at bit timer = TICKS_BIT/2 the class must be T1200, otherwise IDLE plus `vis_err`.
- **VIS:** 8 bits, LSB first. Bit i is sampled at `(i+1)·TICKS_BIT + TICKS_BIT/2` from the start edge.
  - T1100 = 1, T1300 = 0, any other class → IDLE plus `vis_err`.
  - Bits 0–6 form the code; bit 7 is the parity bit.
  - Parity is even over all 8 bits.
- **STOP:** sampled at `9·TICKS_BIT + TICKS_BIT/2`.
  - It must be T1200 and parity must be good. Then `vis_code` ← bits[6:0] and `vis_valid` ← 1.
  - Otherwise IDLE plus `vis_err`, and `vis_valid` stays 0.
  - PIXELS begins at `10·TICKS_BIT`.
- **PIXELS:**
  - The pixel timer runs 0..TICKS_PIXEL−1.
  - At timer = TICKS_PIXEL/2, assert `vid_we` with the current `vid_addr` and the quantized `vid_pixel`.
  - `vid_addr` increments after each strobe.
  - After the write to address 19199, go to IDLE.
  - `freq` is not class-checked in PIXELS.
- **Quantization:** clamp `freq` to [1500, 2300], then `vid_pixel = min((f−1500)/200, 3)`:
  - 1500–1699 → 0
  - 1700–1899 → 1
  - 1900–2099 → 2
  - 2100–2300 → 3
  - Use a 12-bit subtract and compare thresholds; no divider.

## Timing
- **Reset values:**
  - `vis_code` 0, `vis_valid` 0, `vis_err` 0
  - `vid_addr` 0, `vid_pixel` 0, `vid_we` 0, `busy` 0
  - State is IDLE.
- **Reset mid-operation:** asserting `reset` in any state, PIXELS included, aborts the frame immediately. No further `vid_we` is issued.
- **Latency:** decisions see `freq` 1 cycle late (classifier register). All sample instants are measured on the classified stream.
- **Simultaneous qualification and class change:** a class change on the same cycle that the run reaches LEADER_MIN counts as qualified.
- **Strobe spacing:** `vid_we` pulses are exactly TICKS_PIXEL cycles apart.
- **Counter widths:**
  - Run and bit counters are 16 bits and saturate at their maximum; they never wrap.
  - `vid_addr` never exceeds 19199.
- **VIS timing tolerance:** ±TICKS_BIT/2 cumulative drift over 10 bits is tolerated by mid-bit sampling.

## Structure
- **Package `sstv_pkg`:**
  - Tone constants FREQ_1100/1200/1300/1900, FREQ_BLACK = 1500, FREQ_WHITE = 2300.
  - Frame geometry IMG_W = 160, IMG_H = 120, PIX_TOTAL = 19200.
  - `state_t` and `tone_t` enums.
- **Sub-module `sstv_tone_class`:** registered classifier, with `FREQ_TOL` as a parameter.

## Test plan
- **Nominal frame:** header of 300 ms 1900, 10 ms 1200, 300 ms 1900, 30 ms 1200; VIS byte 0x88 LSB first; stop bit 1200; then 19200 pixels.
  - Response: `vis_code` = 7'h08 and `vis_valid` = 1 before the first `vid_we`.
  - Exactly 19200 strobes with addresses 0..19199, then `busy` = 0.
- **Parity error:** VIS byte 0x08 (bit 7 = 0) → one `vis_err` pulse, `vis_valid` = 0, no `vid_we`, state IDLE.
- **Short leader:** 100 ms of 1900 followed by 1200 → return to IDLE, no `vis_err`, `busy` drops. A following full header then decodes normally.
- **Quantization:** hold `freq` at 1400, 1699, 1700, 2099, 2100, 4095 for one pixel each → `vid_pixel` = 0, 0, 1, 2, 3, 3.
- **Reset mid-frame:** assert `reset` at pixel 5000 → all outputs at reset values within the same cycle, and no `vid_we` afterwards.
- **Bad VIS tone:** `freq` = 1700 during bit 3 → `vis_err`, IDLE, `vis_valid` = 0.
